// File: rtl/decomp_pkg.sv
// Shared FSM state encoding and instruction-format constants for the decompressor control path.
package decomp_pkg;
  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EMIT2    = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_CFG      = 3'd5
  } state_t;

  localparam logic [3:0] OPCODE  = 4'b1111;
  localparam int         ENC_LEN = 4;
  localparam int         PCADD   = 4;
endpackage

// File: rtl/decomp_wdog.sv
// Fetch watchdog: counts waiting cycles and pulses tc on the last one, then wraps to zero.
module decomp_wdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = inc & (cnt_q == TC_VAL);
    cnt_d = cnt_q;
    if (clr || tc) cnt_d = '0;
    else if (inc)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/decomp_sequencer.sv
// Control FSM for the instruction decompressor: fetch, decode, 1/2-word emit, redirect and
// token-table config windows. Drives datapath mux/enable nets.
module decomp_sequencer
  import decomp_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_valid,
  input  logic encode,
  input  logic cpu_adv,
  input  logic branch,
  input  logic cfg_req,
  output logic mem_req,
  output logic pc_en,
  output logic branch_mux,
  output logic in_buf_en,
  output logic table_mux,
  output logic out_mux,
  output logic out_buf1_en,
  output logic out_buf2_en,
  output logic cpu_stall,
  output logic cfg_grant,
  output logic fetch_err
);
  state_t state_q, state_d;
  logic   fetch_err_q, fetch_err_d;
  logic   wd_inc, wd_clr, wd_tc;

  decomp_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk  (clk),
    .reset(reset),
    .clr  (wd_clr),
    .inc  (wd_inc),
    .tc   (wd_tc)
  );

  assign wd_inc = (state_q == ST_FETCH) & ~cfg_req & ~branch & ~mem_valid;
  assign wd_clr = (state_q != ST_FETCH) | (state_d != ST_FETCH);

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    pc_en       = 1'b0;
    branch_mux  = 1'b1;
    in_buf_en   = 1'b0;
    table_mux   = 1'b0;
    out_mux     = 1'b0;
    out_buf1_en = 1'b0;
    out_buf2_en = 1'b0;
    cpu_stall   = 1'b1;
    cfg_grant   = 1'b0;
    unique case (state_q)
      ST_RST: begin
        pc_en   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (cfg_req)        state_d = ST_CFG;
        else if (branch)    state_d = ST_REDIRECT;
        else if (mem_valid) begin
          in_buf_en = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cpu_stall   = 1'b0;
        branch_mux  = 1'b0;
        pc_en       = 1'b1;
        out_buf1_en = 1'b1;
        if (encode) begin
          table_mux   = 1'b1;
          out_buf2_en = 1'b1;
          state_d     = ST_EMIT2;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EMIT2: begin
        // A redirect wins over the CPU consuming the first word: the second token is dropped.
        if (branch) state_d = ST_REDIRECT;
        else if (cpu_adv) begin
          out_mux     = 1'b1;
          out_buf1_en = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_REDIRECT: begin
        pc_en   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_CFG: begin
        cfg_grant = 1'b1;
        if (!cfg_req) state_d = ST_REDIRECT;
      end
      default: state_d = ST_RST;
    endcase

    // Reset forces the quiescent output set so no enable or table write leaks through.
    if (reset) begin
      mem_req     = 1'b0;
      pc_en       = 1'b0;
      branch_mux  = 1'b1;
      in_buf_en   = 1'b0;
      table_mux   = 1'b0;
      out_mux     = 1'b0;
      out_buf1_en = 1'b0;
      out_buf2_en = 1'b0;
      cpu_stall   = 1'b1;
      cfg_grant   = 1'b0;
    end
  end

  assign fetch_err_d = fetch_err_q | wd_tc;
  assign fetch_err   = fetch_err_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RST;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_err_q <= fetch_err_d;
    end
  end
endmodule

// File: tb/tb_decomp_sequencer.sv
// Directed bench for decomp_sequencer: per-cycle expected output vectors queued and checked mid-cycle.
module tb_decomp_sequencer;
  import decomp_pkg::*;

  logic clk, reset, mem_valid, encode, cpu_adv, branch, cfg_req;
  logic mem_req, pc_en, branch_mux, in_buf_en, table_mux, out_mux;
  logic out_buf1_en, out_buf2_en, cpu_stall, cfg_grant, fetch_err;

  decomp_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .encode(encode), .cpu_adv(cpu_adv),
    .branch(branch), .cfg_req(cfg_req), .mem_req(mem_req), .pc_en(pc_en),
    .branch_mux(branch_mux), .in_buf_en(in_buf_en), .table_mux(table_mux), .out_mux(out_mux),
    .out_buf1_en(out_buf1_en), .out_buf2_en(out_buf2_en), .cpu_stall(cpu_stall),
    .cfg_grant(cfg_grant), .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output vector bit positions
  localparam logic [10:0] RQ  = 11'd1 << 10;
  localparam logic [10:0] PE  = 11'd1 << 9;
  localparam logic [10:0] BM  = 11'd1 << 8;
  localparam logic [10:0] IB  = 11'd1 << 7;
  localparam logic [10:0] TM  = 11'd1 << 6;
  localparam logic [10:0] OM  = 11'd1 << 5;
  localparam logic [10:0] OB1 = 11'd1 << 4;
  localparam logic [10:0] OB2 = 11'd1 << 3;
  localparam logic [10:0] ST  = 11'd1 << 2;
  localparam logic [10:0] CG  = 11'd1 << 1;
  localparam logic [10:0] ER  = 11'd1;

  localparam logic [10:0] V_RES  = BM | ST;
  localparam logic [10:0] V_RST  = PE | BM | ST;
  localparam logic [10:0] V_FI   = RQ | BM | ST;
  localparam logic [10:0] V_FV   = RQ | BM | ST | IB;
  localparam logic [10:0] V_DRAW = OB1 | PE;
  localparam logic [10:0] V_DENC = TM | OB1 | OB2 | PE;
  localparam logic [10:0] V_EW   = BM | ST;
  localparam logic [10:0] V_EADV = OM | OB1 | BM | ST;
  localparam logic [10:0] V_RED  = BM | PE | ST;
  localparam logic [10:0] V_CFG  = CG | BM | ST;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] word;

  function automatic logic enc_of(input logic [31:0] w);
    return w[31 -: ENC_LEN] == OPCODE;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, check them mid-cycle, then clock.
  task automatic cyc(input string tag, input logic r, input logic mv, input logic en,
                     input logic adv, input logic br, input logic cq, input logic [10:0] ev);
    exp_t e;
    logic [10:0] obs;
    reset = r; mem_valid = mv; encode = en; cpu_adv = adv; branch = br; cfg_req = cq;
    sb.push_back('{tag, ev});
    @(negedge clk);
    e   = sb.pop_front();
    obs = {mem_req, pc_en, branch_mux, in_buf_en, table_mux, out_mux,
           out_buf1_en, out_buf2_en, cpu_stall, cfg_grant, fetch_err};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b0; encode = 1'b0; cpu_adv = 1'b0; branch = 1'b0; cfg_req = 1'b0;

    // 1: reset then RST -> FETCH
    for (int i = 0; i < 3; i++) cyc("reset", 1, 0, 0, 0, 0, 0, V_RES);
    cyc("rst_state", 0, 0, 0, 0, 0, 0, V_RST);

    // 2: raw word
    word = 32'h00A00093;
    cyc("raw_fetch",  0, 1, 0, 0, 0, 0, V_FV);
    cyc("raw_decode", 0, 0, enc_of(word), 0, 0, 0, V_DRAW);

    // 3: compressed word, EMIT2 stalls until cpu_adv
    word = 32'hF0000008;
    cyc("enc_fetch",  0, 1, 0, 0, 0, 0, V_FV);
    cyc("enc_decode", 0, 0, enc_of(word), 0, 0, 0, V_DENC);
    cyc("emit2_wait0", 0, 1, 0, 0, 0, 0, V_EW);
    cyc("emit2_wait1", 0, 0, 0, 0, 0, 0, V_EW);
    cyc("emit2_adv",  0, 0, 0, 1, 0, 0, V_EADV);
    cyc("fetch_after_emit", 0, 0, 0, 0, 0, 0, V_FI);

    // 4: branch with cpu_adv in EMIT2 discards the second word
    cyc("br_fetch",  0, 1, 0, 0, 0, 0, V_FV);
    cyc("br_decode", 0, 0, enc_of(word), 0, 0, 0, V_DENC);
    cyc("emit2_branch", 0, 0, 0, 1, 1, 0, V_EW);
    cyc("redirect", 0, 1, 0, 0, 0, 0, V_RED);

    // 5: fetch timeout after 16 waiting cycles, sticky
    for (int i = 0; i < 16; i++) cyc("fetch_wait", 0, 0, 0, 0, 0, 0, V_FI);
    cyc("fetch_err_set", 0, 0, 0, 0, 0, 0, V_FI | ER);
    cyc("fetch_err_hold", 0, 0, 0, 0, 0, 0, V_FI | ER);

    // 6: cfg_req in EMIT2 is deferred until FETCH; 4-cycle grant then REDIRECT
    cyc("cfg_fetch",  0, 1, 0, 0, 0, 0, V_FV | ER);
    cyc("cfg_decode", 0, 0, enc_of(word), 0, 0, 1, V_DENC | ER);
    cyc("cfg_emit2_wait", 0, 0, 0, 0, 0, 1, V_EW | ER);
    cyc("cfg_emit2_adv",  0, 0, 0, 1, 0, 1, V_EADV | ER);
    cyc("cfg_fetch_req",  0, 0, 0, 0, 0, 1, V_FI | ER);
    for (int i = 0; i < 3; i++) cyc("cfg_grant", 0, 0, 0, 0, 0, 1, V_CFG | ER);
    cyc("cfg_grant_last", 0, 0, 0, 0, 0, 0, V_CFG | ER);
    cyc("cfg_redirect",   0, 0, 0, 0, 0, 0, V_RED | ER);

    // cfg_req and branch together in FETCH -> CFG; reset during CFG drops grant at once
    cyc("cfg_br_fetch", 0, 1, 0, 0, 1, 1, V_FI | ER);
    cyc("cfg_br_grant", 0, 0, 0, 0, 1, 1, V_CFG | ER);
    cyc("cfg_reset",    1, 0, 0, 0, 0, 1, V_RES);
    cyc("post_reset_rst",   0, 0, 0, 0, 0, 1, V_RST);
    cyc("post_reset_fetch", 0, 0, 0, 0, 0, 0, V_FI);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
